// File: rtl/aes_mc_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES MixColumns block.
// Column 0 of a state sits in the most significant word, row 0 in the top byte.
package aes_mc_pkg;

    localparam logic [7:0] GF_RED = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef logic [7:0]        byte_t;
    typedef logic [31:0]       word_t;
    typedef logic [0:3][31:0]  aes_state_t;
    typedef logic [0:3][7:0]   col_bytes_t;

    localparam col_bytes_t FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam col_bytes_t INV_COEF = {8'h0E, 8'h0B, 8'h0D, 8'h09};

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    // Multiply by a constant coefficient: folds to an xtime chain plus XORs.
    function automatic byte_t gf_mul_const(input byte_t a, input byte_t k);
        byte_t acc;
        byte_t p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
// With INV_EN=0 the inverse products are never selected and fold away.
module mix_column_word
    import aes_mc_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic  inv,
    input  word_t col_in,
    output word_t col_out
);

    col_bytes_t a;
    col_bytes_t b_fwd;
    col_bytes_t b_inv;
    logic       inv_sel;

    assign a = col_in;

    if (INV_EN) begin : g_inv
        assign inv_sel = inv;
    end else begin : g_fwd_only
        logic unused_inv;
        assign unused_inv = inv;
        assign inv_sel    = 1'b0;
    end

    // Circulant matrix: row r uses the coefficient vector rotated right by r.
    always_comb begin
        b_fwd = '0;
        b_inv = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                b_fwd[r] = b_fwd[r] ^ gf_mul_const(a[k], FWD_COEF[(k + 4 - r) % 4]);
                b_inv[r] = b_inv[r] ^ gf_mul_const(a[k], INV_COEF[(k + 4 - r) % 4]);
            end
        end
    end

    assign col_out = inv_sel ? b_inv : b_fwd;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle, then holds the result until taken.
module mix_columns_iter
    import aes_mc_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int         C        = COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(4 - C);

    if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cpc
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       inv_q, inv_d;
    aes_state_t work_q, work_d;
    aes_state_t out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;

    word_t col_out [C];

    for (genvar gi = 0; gi < C; gi++) begin : g_col
        logic [1:0] idx;
        assign idx = cnt_q + 2'(gi);
        mix_column_word #(.INV_EN(INV_EN)) u_mcw (
            .inv     (inv_q),
            .col_in  (work_q[idx]),
            .col_out (col_out[gi])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        work_d  = work_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    inv_d   = INV_EN ? in_inv : 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < C; i++) begin
                    work_d[cnt_q + 2'(i)] = col_out[i];
                end
                cnt_d = cnt_q + 2'(C);
                // The result register only changes when a full state is finished.
                if (cnt_q == LAST_CNT) begin
                    out_d   = work_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            work_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            work_q      <= work_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q && rst_n;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench: four engines (C=1,2,4 with inverse, C=4 forward-only),
// randomized round trips checked against a polynomial-arithmetic reference.
module tb_mix_columns_iter;

    logic         clk;
    logic         rst_n     [4];
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [127:0] in_data   [4];
    logic         in_inv    [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [127:0] out_data  [4];

    int           ready_mode [4];
    logic [127:0] exp_q [4][$];
    logic [127:0] exp_tmp;
    logic [127:0] held [4];
    logic [127:0] stall_data [4];
    logic         stall_prev [4];
    logic         prev_ov [4];
    int           acc_cyc [4];
    int           delivered [4];
    int           cyc;
    bit           chk_en;
    int           checks;
    int           failures;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        mix_columns_iter #(
            .COLS_PER_CYCLE (gi == 0 ? 1 : (gi == 1 ? 2 : 4)),
            .INV_EN         (gi != 3)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[gi]),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .in_inv    (in_inv[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (out_data[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int nlat(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    // Reference: carry-less product followed by long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
        logic [7:0]   m [4];
        logic [7:0]   a;
        logic [127:0] r;
        r = '0;
        if (inv) m = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                for (int k = 0; k < 4; k++) begin
                    a = s[127 - 32*c - 8*k -: 8];
                    r[127 - 32*c - 8*row -: 8] = r[127 - 32*c - 8*row -: 8]
                                                 ^ gmul_ref(m[(k - row + 4) % 4], a);
                end
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h exp=%h", nm, i, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            case (ready_mode[i])
                0:       out_ready[i] = 1'b0;
                1:       out_ready[i] = 1'b1;
                default: out_ready[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks timing/holding.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (chk_en && rst_n[i]) begin
                if (out_valid[i]) begin
                    if (!prev_ov[i]) chk("latency", i, 128'(cyc - acc_cyc[i]), 128'(nlat(i)));
                    chk("in_ready_busy", i, 128'(in_ready[i]), 128'(0));
                    if (stall_prev[i]) chk("stall_hold", i, out_data[i], stall_data[i]);
                    if (out_ready[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_result dut%0d got=%h exp=none", i, out_data[i]);
                        end else begin
                            exp_tmp = exp_q[i].pop_front();
                            chk("result", i, out_data[i], exp_tmp);
                            $display("dut%0d result %h", i, out_data[i]);
                        end
                        delivered[i]++;
                        held[i] = out_data[i];
                    end
                end else begin
                    chk("idle_hold", i, out_data[i], held[i]);
                end
                if (in_valid[i] && in_ready[i]) acc_cyc[i] = cyc + 1;
            end
            if (!rst_n[i]) held[i] = '0;
            prev_ov[i]    = out_valid[i];
            stall_prev[i] = out_valid[i] && !out_ready[i];
            stall_data[i] = out_data[i];
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int i, input logic [127:0] d, input logic inv,
                        input logic [127:0] e, input bit push);
        int  t;
        bit  ok;
        t  = 0;
        ok = 1'b0;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_inv[i]   = inv;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (in_ready[i]) ok = 1'b1;
            else begin
                t++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut%0d got=no_accept exp=accept", i);
        end else if (push) begin
            exp_q[i].push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        in_data[i]  = {$urandom, $urandom, $urandom, $urandom};
        in_inv[i]   = 1'($urandom);
    endtask

    task automatic wait_drain(input int i);
        int t;
        t = 0;
        while (exp_q[i].size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain", i, 128'(exp_q[i].size()), 128'(0));
    endtask

    task automatic round_trip(input int i, input int n);
        logic [127:0] s;
        logic [127:0] f;
        for (int k = 0; k < n; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            f = mix_ref(s, 1'b0);
            send(i, s, 1'b0, f, 1'b1);
            send(i, f, 1'b1, s, 1'b1);
        end
    endtask

    task automatic fwd_only(input int n);
        logic [127:0] s;
        for (int k = 0; k < n; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            send(3, s, 1'($urandom), mix_ref(s, 1'b0), 1'b1);
        end
    endtask

    initial begin
        int           d0;
        logic [127:0] s;
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rst_n[i]      = 1'b0;
            in_valid[i]   = 1'b0;
            in_data[i]    = '0;
            in_inv[i]     = 1'b0;
            ready_mode[i] = 1;
            held[i]       = '0;
            prev_ov[i]    = 1'b0;
            stall_prev[i] = 1'b0;
            acc_cyc[i]    = 0;
            delivered[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("in_ready_in_reset", i, 128'(in_ready[i]), 128'(0));
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
        chk_en = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_out_valid", i, 128'(out_valid[i]), 128'(0));
            chk("reset_out_data", i, out_data[i], 128'(0));
            chk("reset_in_ready", i, 128'(in_ready[i]), 128'(1));
        end
        @(posedge clk);
        #1;

        send(0, {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}, 1'b1);
        send(2, {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b0,
                {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}, 1'b1);
        send(1, {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'h01010101}, 1'b1,
                {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'h01010101}, 1'b1);
        repeat (4) begin
            in_inv[1] = ~in_inv[1];
            @(posedge clk);
            #1;
        end
        send(3, {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b1,
                {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}, 1'b1);
        for (int i = 0; i < 4; i++) wait_drain(i);

        // Backpressure with a persistent offer that must not be taken.
        ready_mode[0] = 0;
        d0 = delivered[0];
        s  = {$urandom, $urandom, $urandom, $urandom};
        send(0, s, 1'b0, mix_ref(s, 1'b0), 1'b1);
        in_valid[0] = 1'b1;
        in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
        begin
            int t;
            t = 0;
            while (!out_valid[0] && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("stall_reach_done", 0, 128'(out_valid[0]), 128'(1));
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 0, 128'(in_ready[0]), 128'(0));
        end
        in_valid[0]   = 1'b0;
        ready_mode[0] = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_one_result", 0, 128'(delivered[0] - d0), 128'(1));
        chk("stall_queue_empty", 0, 128'(exp_q[0].size()), 128'(0));

        // Reset after two RUN cycles; the in-flight state must vanish.
        s  = {$urandom, $urandom, $urandom, $urandom};
        d0 = delivered[0];
        send(0, s, 1'b0, '0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n[0] = 1'b0;
        #1;
        chk("midrun_in_ready_low", 0, 128'(in_ready[0]), 128'(0));
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        #1;
        chk("midrun_out_valid", 0, 128'(out_valid[0]), 128'(0));
        chk("midrun_out_data", 0, out_data[0], 128'(0));
        chk("midrun_in_ready", 0, 128'(in_ready[0]), 128'(1));
        repeat (12) @(posedge clk);
        #1;
        chk("midrun_no_stale", 0, 128'(delivered[0] - d0), 128'(0));

        for (int i = 0; i < 4; i++) ready_mode[i] = 2;
        fork
            round_trip(0, 1000);
            round_trip(1, 1000);
            round_trip(2, 1000);
            fwd_only(200);
        join
        for (int i = 0; i < 4; i++) wait_drain(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
